// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROR), one 2:1-mux stage per shamt bit, valid/ready on both sides.
// Optional carry_out port and its pipeline registers are built when BSHIFT_CARRY_OUT_EN is defined.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BSHIFT_CARRY_OUT_EN
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                    input mode_t m,
                                                    input int unsigned n);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MODE_SLL: r = d << n;
            MODE_SRL: r = d >> n;
            MODE_SRA: r = $signed(d) >>> n;
            MODE_ROR: r = (d >> n) | (d << (WIDTH - n));
            default:  r = d;
        endcase
        return r;
    endfunction

`ifdef BSHIFT_CARRY_OUT_EN
    // Bit leaving this stage; the final value equals the last bit shifted out overall.
    function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                         input mode_t m,
                                         input int unsigned n);
        logic [WIDTH-1:0] t;
        if (m == MODE_SLL) t = d >> (WIDTH - n);
        else               t = d >> (n - 1);
        return t[0];
    endfunction
`endif

    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    mode_t            mode_q [SHW];
    logic [SHW-1:0]   valid_q;

    logic [WIDTH-1:0] src_d [SHW];
    logic [SHW-1:0]   src_a [SHW];
    mode_t            src_m [SHW];
    logic [SHW-1:0]   src_v;

    logic [WIDTH-1:0] nxt_d [SHW];
    logic [SHW-1:0]   nxt_a [SHW];

    logic stall;

`ifdef BSHIFT_CARRY_OUT_EN
    logic [SHW-1:0] carry_q;
    logic [SHW-1:0] src_c;
    logic [SHW-1:0] nxt_c;
`endif

    assign out_valid = valid_q[SHW-1];
    assign dout      = data_q[SHW-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
`ifdef BSHIFT_CARRY_OUT_EN
    assign carry_out = carry_q[SHW-1];
`endif

    // Stage inputs: stage 0 takes the port, stage k takes the registers of stage k-1.
    always_comb begin
        src_d[0] = din;
        src_a[0] = shamt;
        src_m[0] = mode_t'(mode);
        src_v    = '0;
        src_v[0] = in_valid;
`ifdef BSHIFT_CARRY_OUT_EN
        src_c    = '0;
`endif
        for (int unsigned k = 1; k < SHW; k++) begin
            src_d[k] = data_q[k-1];
            src_a[k] = amt_q[k-1];
            src_m[k] = mode_q[k-1];
            src_v[k] = valid_q[k-1];
`ifdef BSHIFT_CARRY_OUT_EN
            src_c[k] = carry_q[k-1];
`endif
        end
    end

    // Remaining shamt bits are shifted down so each stage always tests bit 0.
    always_comb begin
`ifdef BSHIFT_CARRY_OUT_EN
        nxt_c = '0;
`endif
        for (int unsigned k = 0; k < SHW; k++) begin
            nxt_a[k] = src_a[k] >> 1;
            nxt_d[k] = src_d[k];
`ifdef BSHIFT_CARRY_OUT_EN
            nxt_c[k] = src_c[k];
`endif
            if (src_a[k][0]) begin
                nxt_d[k] = shift_data(src_d[k], src_m[k], 32'd1 << k);
`ifdef BSHIFT_CARRY_OUT_EN
                nxt_c[k] = shift_carry(src_d[k], src_m[k], 32'd1 << k);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
`ifdef BSHIFT_CARRY_OUT_EN
            carry_q <= '0;
`endif
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= MODE_SLL;
            end
        end else if (!stall) begin
            valid_q <= src_v;
`ifdef BSHIFT_CARRY_OUT_EN
            carry_q <= nxt_c;
`endif
            for (int unsigned k = 0; k < SHW; k++) begin
                data_q[k] <= nxt_d[k];
                amt_q[k]  <= nxt_a[k];
                mode_q[k] <= src_m[k];
            end
        end
    end

endmodule
